// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU); optional DIV_FAST_PATH_EN
module div_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [2:0]                op_i,
  input  logic [DATA_WIDTH-1:0]     dividend_i,
  input  logic [DATA_WIDTH-1:0]     divisor_i,
  input  logic [REG_ADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                      flush_i,
  output logic                      busy_o,
  output logic                      ready_o,
  output logic [DATA_WIDTH-1:0]     result_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     rem_q, rem_d;
  logic [DATA_WIDTH-1:0]     quot_q, quot_d;
  logic [DATA_WIDTH-1:0]     dsr_q, dsr_d;
  logic [DATA_WIDTH-1:0]     dvd_q, dvd_d;
  logic [2:0]                op_q, op_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      q_neg_q, q_neg_d;
  logic                      r_neg_q, r_neg_d;
  logic                      dz_q, dz_d;
  logic                      ov_q, ov_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;

  logic                  signed_op, a_neg, b_neg, accept, dz_c, ov_c, fast, ge;
  logic [DATA_WIDTH:0]   rem_next;
  logic [DATA_WIDTH-1:0] q_fix, r_fix, res_c;

  // Operand decode, one restoring step and the final sign/special-case fixup
  always_comb begin
    signed_op = ~op_i[0];
    a_neg     = signed_op & dividend_i[DATA_WIDTH-1];
    b_neg     = signed_op & divisor_i[DATA_WIDTH-1];
    accept    = start_i & ~flush_i & op_i[2];
    dz_c      = divisor_i == '0;
    ov_c      = signed_op & (dividend_i == MIN_NEG) & (divisor_i == '1);
`ifdef DIV_FAST_PATH_EN
    fast      = dz_c | ov_c;
`else
    fast      = 1'b0;
`endif
    rem_next  = {rem_q, quot_q[DATA_WIDTH-1]};
    ge        = rem_next >= {1'b0, dsr_q};
    q_fix     = dz_q ? '1 : ov_q ? MIN_NEG : q_neg_q ? -quot_q : quot_q;
    r_fix     = dz_q ? dvd_q : ov_q ? '0 : r_neg_q ? -rem_q : rem_q;
    res_c     = op_q[1] ? r_fix : q_fix;
  end

  // Next-state logic for the IDLE -> CALC -> DONE sequence
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dsr_d    = dsr_q;
    dvd_d    = dvd_q;
    op_d     = op_q;
    rd_d     = rd_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dz_d     = dz_q;
    ov_d     = ov_q;
    result_d = result_q;
    waddr_d  = waddr_q;
    if (state_q == IDLE) begin
      if (accept) begin
        quot_d  = a_neg ? -dividend_i : dividend_i;
        dsr_d   = b_neg ? -divisor_i : divisor_i;
        dvd_d   = dividend_i;
        op_d    = op_i;
        rd_d    = reg_waddr_i;
        q_neg_d = a_neg ^ b_neg;
        r_neg_d = a_neg;
        dz_d    = dz_c;
        ov_d    = ov_c;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = fast ? DONE : CALC;
      end
    end else if (state_q == CALC) begin
      if (flush_i) begin
        state_d = IDLE;
      end else begin
        rem_d   = ge ? rem_next[DATA_WIDTH-1:0] - dsr_q : rem_next[DATA_WIDTH-1:0];
        quot_d  = {quot_q[DATA_WIDTH-2:0], ge};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(DATA_WIDTH-1)) ? DONE : CALC;
      end
    end else begin
      state_d  = IDLE;
      result_d = res_c;
      waddr_d  = rd_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dsr_q    <= '0;
      dvd_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
      result_q <= '0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dsr_q    <= dsr_d;
      dvd_q    <= dvd_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dz_q     <= dz_d;
      ov_q     <= ov_d;
      result_q <= result_d;
      waddr_q  <= waddr_d;
    end
  end

  assign busy_o      = state_q != IDLE;
  assign ready_o     = state_q == DONE;
  assign result_o    = ready_o ? res_c : result_q;
  assign reg_waddr_o = ready_o ? rd_q : waddr_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random checks of div_unit against an arithmetic reference model
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, start_i, flush_i, busy_o, ready_o;
  logic [2:0]  op_i;
  logic [31:0] dividend_i, divisor_i, result_o;
  logic [4:0]  reg_waddr_i, reg_waddr_o;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  div_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .reg_waddr_i(reg_waddr_i),
    .flush_i(flush_i), .busy_o(busy_o), .ready_o(ready_o),
    .result_o(result_o), .reg_waddr_o(reg_waddr_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!op[0]) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_FAST_PATH_EN
    return special ? 1 : 33;
`else
    return special ? 33 : 33;
`endif
  endfunction

  task automatic issue_now(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    start_i = 1'b1;
    op_i = op;
    dividend_i = a;
    divisor_i = b;
    reg_waddr_i = rd;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int k0, input int exp_lat, input logic [31:0] er, input logic [4:0] rd);
    int k = k0;
    chk({tag, " busy"}, 32'(busy_o), 32'd1);
    while (!ready_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'(exp_lat));
    chk({tag, " result"}, result_o, er);
    chk({tag, " rd"}, 32'(reg_waddr_o), 32'(rd));
    @(negedge clk);
    chk({tag, " ready drop"}, 32'(ready_o), 32'd0);
    chk({tag, " result hold"}, result_o, er);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input logic [31:0] er);
    @(negedge clk);
    issue_now(op, a, b, rd);
    wait_done(tag, 1, lat(op, a, b), er, rd);
  endtask

  initial begin
    int readies;
    logic [2:0]  op;
    logic [31:0] a, b;
    rst = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i = '0;
    dividend_i = '0;
    divisor_i = '0;
    reg_waddr_i = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset ready", 32'(ready_o), 32'd0);
    chk("reset result", result_o, 32'd0);
    chk("reset rd", 32'(reg_waddr_o), 32'd0);
    rst = 1'b0;

    run("divu 100/7", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14);
    run("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFF);
    run("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFD);
    run("div 1234/0", 3'b100, 32'd1234, 32'd0, 5'd3, 32'hFFFF_FFFF);
    run("remu 1234/0", 3'b111, 32'd1234, 32'd0, 5'd4, 32'd1234);
    run("rem -7/0", 3'b110, 32'hFFFF_FFF9, 32'd0, 5'd6, 32'hFFFF_FFF9);
    run("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000);
    run("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0);
    run("divu big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0);
    run("remu small/big", 3'b111, 32'd5, 32'd9, 5'd10, 32'd5);
    run("div 7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD);
    run("rem 7/-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'd1);

    @(negedge clk);
    start_i = 1'b1;
    op_i = 3'b011;
    dividend_i = 32'd8;
    divisor_i = 32'd2;
    @(negedge clk);
    start_i = 1'b0;
    chk("non-div op ignored", 32'(busy_o), 32'd0);
    start_i = 1'b1;
    op_i = 3'b101;
    flush_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("flush beats start", 32'(busy_o), 32'd0);

    @(negedge clk);
    issue_now(3'b101, 32'd100, 32'd7, 5'd9);
    readies = 0;
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      readies += int'(ready_o);
      if (k == 10) flush_i = 1'b1;
    end
    @(negedge clk);
    flush_i = 1'b0;
    readies += int'(ready_o);
    chk("flush busy", 32'(busy_o), 32'd0);
    chk("flush no ready", 32'(readies), 32'd0);
    chk("flush result kept", result_o, 32'd1);
    issue_now(3'b101, 32'd9, 32'd3, 5'd3);
    wait_done("after flush 9/3", 1, 33, 32'd3, 5'd3);

    @(negedge clk);
    issue_now(3'b101, 32'd1000, 32'd10, 5'd7);
    repeat (4) @(negedge clk);
    start_i = 1'b1;
    op_i = 3'b100;
    dividend_i = 32'd5;
    divisor_i = 32'd1;
    reg_waddr_i = 5'd2;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("start while busy", 6, 33, 32'd100, 5'd7);
    readies = 0;
    repeat (40) begin
      @(negedge clk);
      readies += int'(ready_o);
    end
    chk("start while busy single ready", 32'(readies), 32'd0);

    @(negedge clk);
    issue_now(3'b111, 32'd12345, 32'd77, 5'd11);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst busy", 32'(busy_o), 32'd0);
    chk("mid rst ready", 32'(ready_o), 32'd0);
    chk("mid rst result", result_o, 32'd0);
    chk("mid rst rd", 32'(reg_waddr_o), 32'd0);
    rst = 1'b0;
    readies = 0;
    repeat (40) begin
      @(negedge clk);
      readies += int'(ready_o);
    end
    chk("mid rst no ready", 32'(readies), 32'd0);

    @(negedge clk);
    issue_now(3'b101, 32'd50, 32'd5, 5'd4);
    for (int k = 1; k < 40 && !ready_o; k++) @(negedge clk);
    flush_i = 1'b1;
    chk("flush in done ready", 32'(ready_o), 32'd1);
    chk("flush in done result", result_o, 32'd10);
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush in done committed", result_o, 32'd10);
    chk("flush in done rd", 32'(reg_waddr_o), 32'd4);

    for (int i = 0; i < 60; i++) begin
      op = 3'(4 + $urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
        3: b = 32'($signed(8'($urandom)));
        default: ;
      endcase
      run($sformatf("rand%0d op%0d", i, op), op, a, b, 5'($urandom), model(op, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
